// File: rtl/value_mac_array.sv
// value_mac_array: per-channel signed MAC of FIFO values against an x stream.
// Optional VALUE_MAC_SATURATE_EN: saturating accumulate plus sat_flag port.
module value_mac_array #(
  parameter int CHANNEL_NUM = 4,
  parameter int VAL_BITS    = 8,
  parameter int X_BITS      = 8,
  parameter int ACC_BITS    = 24,
  parameter int LEN_BITS    = 13
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [LEN_BITS-1:0]             row_len,
  input  logic [LEN_BITS-1:0]             row_cnt,
  input  logic [VAL_BITS*CHANNEL_NUM-1:0] val_in,
  input  logic [CHANNEL_NUM-1:0]          val_empty,
  output logic [CHANNEL_NUM-1:0]          val_read,
  input  logic [X_BITS*CHANNEL_NUM-1:0]   x_in,
  input  logic [CHANNEL_NUM-1:0]          x_valid,
  output logic [CHANNEL_NUM-1:0]          x_ready,
  output logic [ACC_BITS*CHANNEL_NUM-1:0] res_out,
  output logic [CHANNEL_NUM-1:0]          res_valid,
  input  logic [CHANNEL_NUM-1:0]          res_ready,
`ifdef VALUE_MAC_SATURATE_EN
  output logic [CHANNEL_NUM-1:0]          sat_flag,
`endif
  output logic                            busy
);
  localparam int PW = VAL_BITS + X_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_e;

  logic [LEN_BITS-1:0]    len_q;
  logic                   busy_q;
  logic [CHANNEL_NUM-1:0] idle;
  logic                   start_ok;

  assign start_ok = start & ~busy_q & (&idle);
  assign busy     = busy_q;

  // Shared row length latch and registered busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (start_ok) len_q <= row_len;
      busy_q <= ~(&idle);
    end
  end

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    state_e               state_q;
    logic [LEN_BITS-1:0]  rows_q;
    logic [LEN_BITS-1:0]  iss_q;
    logic [X_BITS-1:0]    x_q;
    logic                 rd_q;
    logic                 pv_q;
    logic [PW-1:0]        prod_q;
    logic [PW-1:0]        prod_d;
    logic [PW-1:0]        va;
    logic [PW-1:0]        xa;
    logic [ACC_BITS-1:0]  acc_q;
    logic [ACC_BITS-1:0]  acc_d;
    logic [ACC_BITS-1:0]  pext;
    logic [VAL_BITS-1:0]  v;
    logic                 issue;
    logic                 last;
`ifdef VALUE_MAC_SATURATE_EN
    logic [ACC_BITS:0]    sum;
    logic                 ovf;
    logic                 sat_q;
`endif

    assign v    = val_in[g*VAL_BITS +: VAL_BITS];
    assign pext = ACC_BITS'($signed(prod_q));

    // Issue gate, signed product and next accumulator value
    always_comb begin
      issue  = (state_q == RUN) & ~val_empty[g] & x_valid[g]
             & (iss_q < len_q);
      last   = (iss_q + LEN_BITS'(issue)) == len_q;
      va     = {{X_BITS{v[VAL_BITS-1]}}, v};
      xa     = {{VAL_BITS{x_q[X_BITS-1]}}, x_q};
      prod_d = va * xa;
`ifdef VALUE_MAC_SATURATE_EN
      sum   = {acc_q[ACC_BITS-1], acc_q} + {pext[ACC_BITS-1], pext};
      ovf   = sum[ACC_BITS] ^ sum[ACC_BITS-1];
      acc_d = sum[ACC_BITS-1:0];
      if (ovf) begin
        acc_d = sum[ACC_BITS] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                              : {1'b0, {(ACC_BITS-1){1'b1}}};
      end
`else
      acc_d = acc_q + pext;
`endif
    end

    // Channel FSM with operand, product and accumulator pipeline
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= IDLE;
        rows_q  <= '0;
        iss_q   <= '0;
        x_q     <= '0;
        rd_q    <= 1'b0;
        pv_q    <= 1'b0;
        prod_q  <= '0;
        acc_q   <= '0;
`ifdef VALUE_MAC_SATURATE_EN
        sat_q   <= 1'b0;
`endif
      end else begin
        rd_q <= issue;
        pv_q <= rd_q;
        if (issue) x_q <= x_in[g*X_BITS +: X_BITS];
        if (rd_q) prod_q <= prod_d;
        if (pv_q) acc_q <= acc_d;
`ifdef VALUE_MAC_SATURATE_EN
        if (pv_q && ovf) sat_q <= 1'b1;
`endif
        unique case (state_q)
          IDLE: begin
            if (start_ok && row_cnt != '0) begin
              rows_q  <= row_cnt;
              iss_q   <= '0;
              acc_q   <= '0;
`ifdef VALUE_MAC_SATURATE_EN
              sat_q   <= 1'b0;
`endif
              state_q <= (row_len == '0) ? HOLD : RUN;
            end
          end
          RUN: begin
            iss_q <= iss_q + LEN_BITS'(issue);
            if (last) state_q <= DRAIN;
          end
          DRAIN: begin
            if (!rd_q) state_q <= HOLD;
          end
          HOLD: begin
            if (res_ready[g]) begin
              acc_q   <= '0;
              iss_q   <= '0;
              rows_q  <= rows_q - LEN_BITS'(1);
`ifdef VALUE_MAC_SATURATE_EN
              sat_q   <= 1'b0;
`endif
              state_q <= (rows_q == LEN_BITS'(1)) ? IDLE : RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign val_read[g]  = issue;
    assign x_ready[g]   = issue;
    assign res_valid[g] = (state_q == HOLD);
    assign idle[g]      = (state_q == IDLE);
    assign res_out[g*ACC_BITS +: ACC_BITS] =
      (state_q == HOLD) ? acc_q : '0;
`ifdef VALUE_MAC_SATURATE_EN
    assign sat_flag[g] = sat_q;
`endif
  end

endmodule

// File: tb/tb_value_mac_array.sv
// tb_value_mac_array: table vectors plus randomized jobs vs row-level model.
// Reset, backpressure, zero-length rows and mid-row reset sequences.
`timescale 1ns/1ps
module tb_value_mac_array;
  localparam int CH = 4;
  localparam int VB = 8;
  localparam int XB = 8;
  localparam int AB = 16;
  localparam int LB = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LB-1:0]   row_len;
  logic [LB-1:0]   row_cnt;
  logic [VB*CH-1:0] val_in;
  logic [CH-1:0]   val_empty;
  logic [CH-1:0]   val_read;
  logic [XB*CH-1:0] x_in;
  logic [CH-1:0]   x_valid;
  logic [CH-1:0]   x_ready;
  logic [AB*CH-1:0] res_out;
  logic [CH-1:0]   res_valid;
  logic [CH-1:0]   res_ready;
  logic            busy;
`ifdef VALUE_MAC_SATURATE_EN
  logic [CH-1:0]   sat_flag;
`endif

  always #5 clk = ~clk;

  value_mac_array #(
    .CHANNEL_NUM(CH), .VAL_BITS(VB), .X_BITS(XB),
    .ACC_BITS(AB), .LEN_BITS(LB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_len(row_len), .row_cnt(row_cnt),
    .val_in(val_in), .val_empty(val_empty), .val_read(val_read),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready),
`ifdef VALUE_MAC_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  typedef struct {
    int val;
    bit sat;
  } res_t;

  typedef struct {
    int len;
    int rows;
    int v[8];
    int x[8];
    int exp[3];
    bit lat;
    bit dbl;
  } vec_t;

  int   vq[CH][$];
  int   xq[CH][$];
  res_t eq[CH][$];
  int   pass_n = 0;
  int   tot_n = 0;
  bit   stall_en;
  int   rr_mode;
  int   hold_cnt;
  int   cyc_n;
  int   rd0_cnt;
  int   first_iss;
  int   first_rv;
  bit   prev_hold[CH];
  logic [AB-1:0] prev_val[CH];

  task automatic chk(string nm, longint act, longint exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Row dot product with accumulator-width semantics
  function automatic res_t row_model(int v[$], int x[$]);
    longint acc = 0;
    longint mx = (longint'(1) <<< (AB - 1)) - 1;
    longint mn = -(longint'(1) <<< (AB - 1));
    longint md = longint'(1) <<< AB;
    res_t r;
    r.sat = 1'b0;
    foreach (v[k]) begin
      acc += longint'(v[k]) * longint'(x[k]);
`ifdef VALUE_MAC_SATURATE_EN
      if (acc > mx) begin acc = mx; r.sat = 1'b1; end
      if (acc < mn) begin acc = mn; r.sat = 1'b1; end
`endif
    end
`ifndef VALUE_MAC_SATURATE_EN
    acc = ((acc % md) + md) % md;
    if (acc > mx) acc -= md;
`endif
    r.val = int'(acc);
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < CH; i++) begin
      val_empty[i] = (vq[i].size() == 0) ||
                     (stall_en && $urandom_range(0, 2) == 0);
      x_valid[i] = (xq[i].size() != 0) &&
                   !(stall_en && $urandom_range(0, 2) == 0);
      x_in[i*XB +: XB] = (xq[i].size() != 0) ? XB'(xq[i][0]) : '0;
      case (rr_mode)
        0: res_ready[i] = 1'b1;
        1: res_ready[i] = 1'($urandom_range(0, 1));
        default: res_ready[i] = (i != 0) || (hold_cnt >= 10);
      endcase
    end
  endtask

  task automatic cyc();
    logic [CH-1:0] rd;
    logic [CH-1:0] hs;
    logic signed [AB-1:0] ro;
    res_t r;
    @(negedge clk);
    cyc_n++;
    rd = val_read;
    hs = res_valid & res_ready;
    chk("xready_eq_read", x_ready, val_read);
    chk("read_gate", val_read & (val_empty | ~x_valid), 0);
    if (rd[0]) begin
      rd0_cnt++;
      if (first_iss < 0) first_iss = cyc_n;
    end
    if (res_valid[0] && first_rv < 0) first_rv = cyc_n;
    for (int i = 0; i < CH; i++) begin
      ro = res_out[i*AB +: AB];
      if (prev_hold[i] && res_valid[i])
        chk($sformatf("hold_stable%0d", i), ro, $signed(prev_val[i]));
      prev_hold[i] = res_valid[i] && !res_ready[i];
      prev_val[i] = ro;
      if (hs[i]) begin
        if (eq[i].size() == 0) begin
          chk($sformatf("extra_res%0d", i), hs[i], 0);
        end else begin
          r = eq[i].pop_front();
          chk($sformatf("res%0d", i), ro, r.val);
`ifdef VALUE_MAC_SATURATE_EN
          chk($sformatf("sat%0d", i), sat_flag[i], r.sat);
`endif
        end
      end
    end
    if (rr_mode == 2) begin
      if (hs[0]) hold_cnt = 0;
      else if (res_valid[0]) hold_cnt++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (rd[i] && vq[i].size() > 0) begin
        val_in[i*VB +: VB] = VB'(vq[i].pop_front());
        void'(xq[i].pop_front());
      end
    end
    drive_inputs();
  endtask

  task automatic run_job(vec_t t, bit tab);
    int   n;
    bit   pend;
    int   rv[$];
    int   rx[$];
    res_t r;
    for (int c = 0; c < CH; c++) begin
      for (int ro = 0; ro < t.rows; ro++) begin
        rv.delete();
        rx.delete();
        for (int k = 0; k < t.len; k++) begin
          if (tab && c == 0) begin
            rv.push_back(t.v[ro*t.len+k]);
            rx.push_back(t.x[ro*t.len+k]);
          end else begin
            rv.push_back(int'($urandom_range(0, 255)) - 128);
            rx.push_back(int'($urandom_range(0, 255)) - 128);
          end
          vq[c].push_back(rv[k]);
          xq[c].push_back(rx[k]);
        end
        r = row_model(rv, rx);
        if (tab && c == 0) r.val = t.exp[ro];
        eq[c].push_back(r);
      end
    end
    rd0_cnt = 0;
    first_iss = -1;
    first_rv = -1;
    hold_cnt = 0;
    drive_inputs();
    row_len = LB'(t.len);
    row_cnt = LB'(t.rows);
    start = 1'b1;
    cyc();
    start = 1'b0;
    if (t.dbl) begin
      repeat (3) cyc();
      row_len = 7;
      row_cnt = 1;
      start = 1'b1;
      cyc();
      start = 1'b0;
    end
    n = 0;
    pend = 1'b1;
    while (pend && n < 3000) begin
      cyc();
      n++;
      pend = busy;
      for (int c = 0; c < CH; c++) if (eq[c].size() != 0) pend = 1'b1;
    end
    chk("job_timeout", n >= 3000, 0);
    repeat (2) cyc();
    chk("busy_low_after", busy, 0);
    chk("res_valid_low_after", res_valid, 0);
    chk("read_count0", rd0_cnt, t.len * t.rows);
    if (t.lat) chk("latency", first_rv - first_iss, t.len + 2);
  endtask

  initial begin
    vec_t tab[5];
    vec_t rj;

    tab[0].len = 4; tab[0].rows = 1;
    tab[0].v = '{1, 2, 3, 4, 0, 0, 0, 0};
    tab[0].x = '{5, 6, 7, 8, 0, 0, 0, 0};
    tab[0].exp = '{70, 0, 0};
    tab[0].lat = 1; tab[0].dbl = 0;

    tab[1].len = 2; tab[1].rows = 2;
    tab[1].v = '{-3, 127, -1, -1, 0, 0, 0, 0};
    tab[1].x = '{-128, 2, 1, 1, 0, 0, 0, 0};
    tab[1].exp = '{638, -2, 0};
    tab[1].lat = 0; tab[1].dbl = 0;

    tab[2].len = 0; tab[2].rows = 3;
    tab[2].v = '{0, 0, 0, 0, 0, 0, 0, 0};
    tab[2].x = '{0, 0, 0, 0, 0, 0, 0, 0};
    tab[2].exp = '{0, 0, 0};
    tab[2].lat = 0; tab[2].dbl = 1;

    tab[3].len = 4; tab[3].rows = 1;
    tab[3].v = '{127, 127, 127, 127, 0, 0, 0, 0};
    tab[3].x = '{127, 127, 127, 127, 0, 0, 0, 0};
`ifdef VALUE_MAC_SATURATE_EN
    tab[3].exp = '{32767, 0, 0};
`else
    tab[3].exp = '{-1020, 0, 0};
`endif
    tab[3].lat = 0; tab[3].dbl = 0;

    tab[4].len = 1; tab[4].rows = 1;
    tab[4].v = '{5, 0, 0, 0, 0, 0, 0, 0};
    tab[4].x = '{-3, 0, 0, 0, 0, 0, 0, 0};
    tab[4].exp = '{-15, 0, 0};
    tab[4].lat = 1; tab[4].dbl = 0;

    rst = 1'b0;
    start = 1'b0;
    row_len = '0;
    row_cnt = '0;
    val_in = '0;
    val_empty = '1;
    x_in = '0;
    x_valid = '0;
    res_ready = '0;
    stall_en = 1'b0;
    rr_mode = 0;
    hold_cnt = 0;
    cyc_n = 0;
    for (int i = 0; i < CH; i++) begin
      prev_hold[i] = 1'b0;
      prev_val[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_val_read", val_read, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    for (int k = 0; k < 4; k++) begin
      stall_en = 1'b0;
      rr_mode = (k == 1) ? 1 : 0;
      run_job(tab[k], 1'b1);
    end

    stall_en = 1'b1;
    rr_mode = 2;
    rj = tab[0];
    rj.lat = 0;
    rj.len = 5;
    rj.rows = 2;
    run_job(rj, 1'b0);

    rr_mode = 1;
    for (int k = 0; k < 6; k++) begin
      rj.len = $urandom_range(1, 6);
      rj.rows = $urandom_range(1, 3);
      run_job(rj, 1'b0);
    end

    stall_en = 1'b0;
    rr_mode = 0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 8; k++) begin
        vq[c].push_back(int'($urandom_range(0, 255)) - 128);
        xq[c].push_back(int'($urandom_range(0, 255)) - 128);
      end
    drive_inputs();
    row_len = 8;
    row_cnt = 1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("midrow_reading", val_read[0], 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_val_read", val_read, 0);
    chk("mrst_x_ready", x_ready, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_out", res_out, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b1;
    for (int c = 0; c < CH; c++) begin
      vq[c].delete();
      xq[c].delete();
      eq[c].delete();
      prev_hold[c] = 1'b0;
    end
    val_in = '0;
    drive_inputs();
    run_job(tab[4], 1'b1);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/value_mac_array.md
Name: value_mac_array

Overview:
- Downstream consumer of the value fetcher's per-channel value FIFOs.
- Each channel pops matrix values from its FIFO and the matching vector operand from an x stream, then multiply-accumulates them over a programmable row length.
- Each finished row dot-product is emitted on a per-channel valid/ready result port.
- Channels run independently; a shared start latches the row length and the row count for all channels.

Parameters:
CHANNEL_NUM, 4, number of channels (matches value fetcher channel count)
VAL_BITS, 8, signed matrix value width
X_BITS, 8, signed vector operand width
ACC_BITS, 24, accumulator/result width (must be >= VAL_BITS+X_BITS)
LEN_BITS, 13, row length / row count width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  pulse; latches row_len and row_cnt, all channels begin
row_len  in  LEN_BITS  products per row
row_cnt  in  LEN_BITS  rows per channel per job
val_in  in  VAL_BITS*CHANNEL_NUM  FIFO dout; channel i at [i*VAL_BITS+:VAL_BITS]
val_empty  in  CHANNEL_NUM  FIFO empty flags
val_read  out  CHANNEL_NUM  FIFO rd_en
x_in  in  X_BITS*CHANNEL_NUM  vector operands
x_valid  in  CHANNEL_NUM  operand valid
x_ready  out  CHANNEL_NUM  operand accepted
res_out  out  ACC_BITS*CHANNEL_NUM  row results
res_valid  out  CHANNEL_NUM  result valid
res_ready  in  CHANNEL_NUM  result accepted
busy  out  1  any channel not IDLE

Behaviour:
- Reset (rst low at posedge):
  - all channels go to IDLE.
  - val_read, x_ready, res_valid = 0; res_out = 0; busy = 0.
  - accumulators, counters and pipeline valids are cleared.
  - in-flight FIFO data is discarded; a FIFO read already issued is lost.
- FIFO timing: non-first-word-fall-through; val_in[i] is valid the cycle after val_read[i] is high.
- Per-channel FSM has states IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - start is honoured only when all channels are IDLE (busy=0); start while busy is ignored.
  - On start, latch len and rows.
  - rows==0 -> stay IDLE.
  - len==0 -> go directly to HOLD with acc=0 for every row.
  - Otherwise -> RUN.
- RUN issue:
  - val_read[i] = x_ready[i] = (state==RUN) & ~val_empty[i] & x_valid[i] & (issued<len); combinational.
  - On issue, register x_in[i] and increment issued.
- Pipeline:
  - Cycle +1: product = signed val_in[i] * signed x_reg, registered (VAL_BITS+X_BITS, sign-extended).
  - Cycle +2: acc <= acc + product, wrapping mod 2^ACC_BITS.
  - Throughput is one product per cycle per channel.
- RUN -> DRAIN when issued==len.
- DRAIN -> HOLD when both pipeline stages are empty (2 cycles after the last issue).
- HOLD:
  - res_valid[i]=1 and res_out[i]=acc; res_out is stable while res_valid is high and ~res_ready.
  - On res_valid&res_ready: clear acc and issued, decrement rows_left.
  - rows_left reaching 0 -> IDLE, else -> RUN; res_valid drops the next cycle.
- Minimum row latency from first issue to res_valid is len+2 cycles with no stalls.
- busy = OR over channels of (state != IDLE), registered.
- FIFO empty or x_valid low simply stalls issue; the pipeline still drains.
- A stalled result (res_ready low) blocks that channel only.

Optional Feature:
- Macro: VALUE_MAC_SATURATE_EN.
- Defined: accumulation saturates to the signed ACC_BITS range (max 2^(ACC_BITS-1)-1, min -2^(ACC_BITS-1)). A per-channel sticky flag is cleared on result handoff, and its state is reported in a one-bit-per-channel output port sat_flag.
- Undefined: accumulation wraps; sat_flag is absent.

Test Plan:
- Basic row: len=4, rows=1, ch0 values {1,2,3,4}, x {5,6,7,8} -> res_out[0]=70, res_valid rises 6 cycles after first issue; busy falls after handoff.
- Signed and multi-row: len=2, rows=2, values {-3,127} x {-128,2} -> row result 638. Second row {-1,-1} x {1,1} -> -2. Channel returns to IDLE after the second handoff.
- Backpressure and stalls: toggle val_empty and x_valid randomly while res_ready is held low 10 cycles -> no read issued while empty or x invalid, res_out stable during hold, correct sum.
- Boundary: len=0, rows=3 -> three results of 0 with no val_read. start while busy -> ignored; len remains latched.
- Reset mid-row: drive rst low during a RUN with 2 products in flight -> all outputs 0 next cycle. A new start with len=1 gives the correct single product with no residue.
- Saturation (VALUE_MAC_SATURATE_EN defined): ACC_BITS=16, 4 x (127*127) -> res_out=32767, sat_flag[0]=1. Without the macro -> wrapped value 64516 mod 65536 = -1020.
